// File: rtl/pipe_elastic_chain.sv
// Elastic chain of DEPTH pipeline registers with per-stage valid bits and bubble collapse.
// Latency: DEPTH cycles from an input transfer to ou_valid when nothing stalls; 1 word/cycle.
// Backpressure: ready ripples combinationally from ou_ready; an empty stage always accepts.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears valids, data and counter)
//   flush           synchronous squash of every in-flight word; blocks input that cycle
//   in_valid/in_ready/in_data   producer handshake into stage 0
//   ou_valid/ou_ready/ou_data   consumer handshake out of stage DEPTH-1
//   occupancy       number of valid stages (0..DEPTH)
//   stall_count     cycles with ou_valid && !ou_ready, saturating; only built when
//                   PIPE_STAT_EN is defined, otherwise tied to zero
module pipe_elastic_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       ou_valid,
    input  logic                       ou_ready,
    output logic [WIDTH-1:0]           ou_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [31:0]                stall_count
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    // w_rdy[i]: stage i may load this edge. w_rdy[DEPTH] is the consumer.
    logic [DEPTH:0]   w_rdy;
    logic [OCC_W-1:0] w_occ;

    // A stage can take a new word if it is empty (bubble collapse) or if
    // the stage in front of it is also moving. Evaluated from the output
    // side so ou_ready reaches in_ready in the same cycle.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = ou_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = !r_valid[i] || w_rdy[i+1];
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign in_ready  = w_rdy[0] && !flush;
    assign ou_valid  = r_valid[DEPTH-1];
    assign ou_data   = r_data[DEPTH-1];
    assign occupancy = w_occ;

    // Flush only drops the valid bits; data registers keep their contents
    // since an invalid stage's data is never observed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_rdy[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end
    end

`ifdef PIPE_STAT_EN
    logic [31:0] r_stall_cnt;

    // Counts consumer stalls only; flush leaves history intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (ou_valid && !ou_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Scoreboard bench for pipe_elastic_chain (WIDTH=32, DEPTH=4).
// Stimulus pushes accepted words into exp_q; a negedge monitor pops on each output transfer.
// Directed per-cycle vectors check in_ready, occupancy and ou_valid against hand-derived values.
module tb_pipe_elastic_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef PIPE_STAT_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ou_valid;
    logic             ou_ready;
    logic [WIDTH-1:0] ou_data;
    logic [2:0]       occupancy;
    logic [31:0]      stall_count;

    int tests;
    int fails;
    logic [WIDTH-1:0] exp_q [$];

    pipe_elastic_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .ou_valid    (ou_valid),
        .ou_ready    (ou_ready),
        .ou_data     (ou_data),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && ou_valid && ou_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected no output", ou_data);
            end else begin
                chk("ou_data", ou_data, exp_q.pop_front());
            end
        end
    end

    // One cycle: drive at posedge+1, check at negedge. exp_occ/exp_ov < 0 skips.
    // Flush discards the queue after the flush cycle's own output transfer was popped.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic ordy, input logic fl, input logic exp_ir,
                        input int exp_occ, input int exp_ov);
        in_valid = v;
        in_data  = d;
        ou_ready = ordy;
        flush    = fl;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ir});
        if (exp_occ >= 0) chk({tag, ".occupancy"}, {29'd0, occupancy}, 32'(exp_occ));
        if (exp_ov >= 0)  chk({tag, ".ou_valid"}, {31'd0, ou_valid}, 32'(exp_ov));
        if (v && exp_ir) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ou_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".ou_valid"}, {31'd0, ou_valid}, 32'd0);
        chk({tag, ".ou_data"}, ou_data, 32'd0);
        chk({tag, ".occupancy"}, {29'd0, occupancy}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".stall_count"}, stall_count, 32'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    int bub_occ [10] = '{0, 1, 1, 2, 2, 2, 2, 2, 1, 0};
    int bub_ov  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ou_ready = 1'b0;

        do_reset("reset");

        // Streaming: words 1..8, first output in cycle 4, steady occupancy 4.
        for (int k = 0; k < 13; k++) begin
            step($sformatf("stream%0d", k), k < 8, 32'(k + 1), 1'b1, 1'b0, 1'b1,
                 (k <= 4) ? k : ((k <= 8) ? 4 : 12 - k), (k >= 4 && k <= 11) ? 1 : 0);
        end

        // Backpressure: A0..A3 fill the chain, A4 waits until ou_ready rises.
        for (int k = 0; k < 12; k++) begin
            step($sformatf("bp%0d", k), k <= 6, 32'hA0 + 32'((k < 4) ? k : 4),
                 k >= 6, 1'b0, (k <= 3 || k >= 6),
                 (k <= 4) ? k : ((k <= 7) ? 4 : 11 - k), (k >= 4 && k <= 10) ? 1 : 0);
        end

        // Bubble collapse: 0x55 then 0x66 with a gap, both packed at the output end.
        for (int k = 0; k < 10; k++) begin
            step($sformatf("bubble%0d", k), (k == 0 || k == 2), (k == 0) ? 32'h55 : 32'h66,
                 k >= 7, 1'b0, 1'b1, bub_occ[k], bub_ov[k]);
            if (k == 6) chk("bubble.stage3", ou_data, 32'h55);
        end

        // Flush with occupancy 3: 0xDEAD blocked, everything squashed.
        for (int k = 0; k < 3; k++) begin
            step($sformatf("flushA%0d", k), 1'b1, 32'hB1 + 32'(k), 1'b0, 1'b0, 1'b1, k, 0);
        end
        step("flushA3", 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 3, 0);
        step("flushA4", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);
        step("flushA5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);

        // Flush on a full chain while the consumer takes the head word.
        for (int k = 0; k < 4; k++) begin
            step($sformatf("flushB%0d", k), 1'b1, 32'hC1 + 32'(k), 1'b0, 1'b0, 1'b1, k, 0);
        end
        step("flushB4", 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0, 4, 1);
        step("flushB5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);
        step("flushB6", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);

        // Mid-stream reset discards in-flight words.
        step("midrst0", 1'b1, 32'hF1, 1'b1, 1'b0, 1'b1, 0, 0);
        step("midrst1", 1'b1, 32'hF2, 1'b1, 1'b0, 1'b1, 1, 0);
        do_reset("midrst");
        for (int k = 0; k < 6; k++) begin
            step($sformatf("postrst%0d", k), 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);
        end

        // Stall counter: 10 stalled cycles, survives flush, cleared by reset.
        do_reset("stat_rst");
        step("stat0", 1'b1, 32'hE1, 1'b0, 1'b0, 1'b1, 0, 0);
        for (int k = 1; k < 14; k++) begin
            step($sformatf("stat%0d", k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1,
                 1, (k >= 4) ? 1 : 0);
        end
        chk("stat.count10", stall_count, (STAT_ON != 0) ? 32'd10 : 32'd0);
        step("stat14", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1, 1);
        chk("stat.after_flush", stall_count, (STAT_ON != 0) ? 32'd10 : 32'd0);
        step("stat15", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0);
        chk("stat.hold", stall_count, (STAT_ON != 0) ? 32'd10 : 32'd0);
        do_reset("stat_clear");

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d words outstanding expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_chain.md
Name: pipe_elastic_chain

Overview:
- Parametrised successor to the fixed IF_ID/ID_EX/EX_MEM/MEM_WB stage registers of the 5-stage datapath.
- A chain of DEPTH pipeline registers, each WIDTH bits, with per-stage valid bits and valid/ready backpressure.
- Bubbles collapse, and a synchronous flush squashes all in-flight words.
- Used between datapath stages wherever stall/flush is needed for hazard handling.

Parameters:
WIDTH, 32, data bits per stage
DEPTH, 4, number of register stages (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous squash of all stages
in_valid  input  1  producer has a word on in_data
in_ready  output  1  chain accepts in_data this cycle
in_data  input  WIDTH  producer word
ou_valid  output  1  last stage holds a valid word
ou_ready  input  1  consumer accepts ou_data this cycle
ou_data  output  WIDTH  last-stage word
occupancy  output  $clog2(DEPTH+1)  number of valid stages
stall_count  output  32  output-stall counter (see Optional Feature)

Behaviour:
- Stage state: valid[i] and data[i], i=0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives ou_valid/ou_data directly.
- Ready chain (combinational): rdy[DEPTH]=ou_ready; rdy[i]=!valid[i] || rdy[i+1]; in_ready=rdy[0] && !flush.
- Per-edge update, i>0:
  - if rdy[i]: valid[i]<=valid[i-1], data[i]<=data[i-1].
  - else: hold.
- Stage 0:
  - if rdy[0]: valid[0]<=in_valid && !flush, data[0]<=in_data.
  - else: hold.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when ou_valid && ou_ready.
- Latency: a word presented in cycle n with no stalls is on ou_data with ou_valid=1 in cycle n+DEPTH. Throughput is 1 word/cycle.
- Bubble collapse: an invalid stage always accepts from the stage behind it, even when downstream stalls. A full chain with ou_ready=0 has in_ready=0.
- ou_ready rising while the chain is full gives in_ready=1 in the same cycle (combinational path). Simultaneous input and output transfer keeps occupancy constant.
- Data in invalid stages is don't-care but must never appear with ou_valid=1.
- flush=1:
  - next edge clears all valid[i]; data is held.
  - in_ready=0 during the flush cycle, so no input transfer occurs.
  - an output transfer occurring in the flush cycle is still a legal consumption by the consumer.
- rst=1: all valid[i]=0, all data[i]=0 at the next edge. rst has priority over flush and all transfers. Mid-stream reset discards all words.
- Reset values: ou_valid=0, ou_data=0, occupancy=0, stall_count=0. in_ready=1 after reset (if flush=0).
- occupancy: combinational popcount of valid[], range 0..DEPTH.
- DEPTH=1: a single register, where in_ready=!valid[0] || ou_ready.

Optional Feature:
- Macro: PIPE_STAT_EN.
- Defined:
  - stall_count increments each cycle with ou_valid && !ou_ready.
  - It saturates at 32'hFFFFFFFF.
  - It is cleared by rst only; flush does not clear it.
- Undefined: stall_count is tied to 0 and no counter logic is present.

Test Plan:
- Reset: rst=1 for 2 cycles, flush=0 -> ou_valid=0, ou_data=0, occupancy=0, in_ready=1, stall_count=0.
- Streaming (DEPTH=4): ou_ready=1, words 0x00000001..0x00000008 on consecutive cycles from cycle 0 -> ou_valid first high in cycle 4, words emerge in order one per cycle through cycle 11, occupancy=4 during the steady state.
- Backpressure: ou_ready=0, push 0xA0..0xA4 back-to-back -> 0xA0..0xA3 accepted, in_ready=0 when 0xA4 is presented, occupancy=4. Then raise ou_ready -> 0xA4 accepted in that same cycle, and 0xA0..0xA4 are output in order with no loss or duplicate.
- Bubble collapse: ou_ready=0, push 0x55 in cycle 0 and 0x66 in cycle 2 -> by cycle 6, stage3=0x55 and stage2=0x66, occupancy=2, in_ready=1.
- Flush: occupancy=3, flush=1 for one cycle with in_valid=1, in_data=0xDEAD -> next cycle occupancy=0, ou_valid=0. 0xDEAD is never output, and in_ready=0 during the flush cycle.
- Stat (PIPE_STAT_EN defined): hold ou_ready=0 for 10 cycles while ou_valid=1 -> stall_count=10. A subsequent flush leaves it at 10; rst returns it to 0.
